// File: rtl/l2_mem_bus_arbiter.sv
// Round-robin arbiter sharing the MainMemory port between the L2 line-fill engine (0)
// and the L2 write-back buffer (1). Optional ARB_STATS_EN adds saturating statistics counters.
module l2_mem_bus_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BURST_BEATS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        wr_next,
  output logic [1:0]        rd_valid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        done,
  output logic              mem_addrstb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stb
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_grants0,
  output logic [31:0]       stat_grants1,
  output logic [31:0]       stat_contention,
  output logic [31:0]       stat_wait
`endif
);

  localparam int unsigned BEAT_W = $clog2(BURST_BEATS);
  localparam int unsigned OFF_W  = BEAT_W + 3;

  typedef enum logic [1:0] {IDLE, ADDR, XFER, DONE} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               ptr_q;
  logic               we_q;
  logic [ADDR_W-1:0]  base_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [ADDR_W-1:0]  sel_addr;
  logic [1:0]         owner_oh;
  logic               beat_fire;
  logic               last_beat;
  logic               unused_offset;

  assign owner_oh      = owner_q ? 2'b10 : 2'b01;
  assign beat_fire     = (state_q == XFER) && mem_stb;
  assign last_beat     = (beat_q == BEAT_W'(BURST_BEATS - 1));
  assign sel_addr      = owner_d ? req_addr1 : req_addr0;
  assign unused_offset = ^{req_addr0[OFF_W-1:0], req_addr1[OFF_W-1:0]};

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: if (|req) begin
        owner_d = (req == 2'b11) ? ptr_q : req[1];
        state_d = ADDR;
      end
      ADDR: state_d = XFER;
      XFER: if (beat_fire && last_beat) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      we_q     <= 1'b0;
      base_q   <= '0;
      beat_q   <= '0;
      rd_valid <= '0;
      rdata    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (state_q == IDLE && (|req)) begin
        we_q   <= req_we[owner_d];
        base_q <= {sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end
      if (state_q == DONE) begin
        beat_q <= '0;
        ptr_q  <= ~owner_q;
      end else if (beat_fire) begin
        beat_q <= beat_q + 1'b1;
      end
      // Read beat is registered, so its valid pulse trails the memory strobe by one cycle.
      rd_valid <= (beat_fire && !we_q) ? owner_oh : '0;
      if (beat_fire && !we_q) rdata <= mem_rdata;
    end
  end

  always_comb begin
    gnt         = (state_q != IDLE) ? owner_oh : '0;
    mem_addrstb = (state_q == ADDR);
    mem_we      = ((state_q == ADDR) || (state_q == XFER)) && we_q;
    mem_addr    = '0;
    if (state_q == ADDR) mem_addr = base_q;
    else if (state_q == XFER) mem_addr = {base_q[ADDR_W-1:OFF_W], beat_q, 3'b000};
    mem_wdata   = '0;
    if (state_q == XFER && we_q) mem_wdata = owner_q ? req_wdata1 : req_wdata0;
    wr_next     = (beat_fire && we_q) ? owner_oh : '0;
    done        = (state_q == DONE) ? owner_oh : '0;
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants0    <= '0;
      stat_grants1    <= '0;
      stat_contention <= '0;
      stat_wait       <= '0;
    end else begin
      if (state_q == IDLE && state_d == ADDR) begin
        if (!owner_d && stat_grants0 != '1) stat_grants0 <= stat_grants0 + 32'd1;
        if (owner_d && stat_grants1 != '1) stat_grants1 <= stat_grants1 + 32'd1;
      end
      if (state_q == IDLE && req == 2'b11 && stat_contention != '1)
        stat_contention <= stat_contention + 32'd1;
      if (state_q == XFER && !mem_stb && stat_wait != '1)
        stat_wait <= stat_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_mem_bus_arbiter.sv
// Scoreboard bench for l2_mem_bus_arbiter: directed stimulus queues expected memory/requester
// events; a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_l2_mem_bus_arbiter;

  localparam logic [63:0] W0 = 64'h1111_0000_0000_0000;
  localparam logic [63:0] W1 = 64'h2222_0000_0000_0000;

  typedef enum int {K_ADDR, K_WR, K_RD, K_DONE} kind_t;
  typedef struct {
    kind_t       kind;
    logic [1:0]  vec;
    logic [31:0] addr;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0, req_we = '0;
  logic [31:0] req_addr0 = '0, req_addr1 = '0;
  logic [63:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]  gnt, wr_next, rd_valid, done;
  logic [63:0] rdata, mem_wdata, mem_rdata;
  logic        mem_addrstb, mem_we;
  logic        mem_stb = 1'b0;
  logic [31:0] mem_addr;
`ifdef ARB_STATS_EN
  logic [31:0] stat_grants0, stat_grants1, stat_contention, stat_wait;
`endif

  l2_mem_bus_arbiter #(.ADDR_W(32), .DATA_W(64), .BURST_BEATS(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .gnt(gnt), .wr_next(wr_next), .rd_valid(rd_valid), .rdata(rdata), .done(done),
    .mem_addrstb(mem_addrstb), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stb(mem_stb)
`ifdef ARB_STATS_EN
    , .stat_grants0(stat_grants0), .stat_grants1(stat_grants1),
    .stat_contention(stat_contention), .stat_wait(stat_wait)
`endif
  );

  always #5 clk = ~clk;

  // Memory returns {address, ~address} for every read beat.
  function automatic logic [63:0] mem_model(input logic [31:0] a);
    return {a, ~a};
  endfunction
  assign mem_rdata = mem_model(mem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input kind_t k, input logic [1:0] v, input logic [31:0] a, input logic [63:0] d);
    exp_t e;
    e.kind = k; e.vec = v; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_burst(input int idx, input bit we, input logic [31:0] base);
    logic [1:0] oh;
    oh = (idx == 0) ? 2'b01 : 2'b10;
    push(K_ADDR, oh, base, {63'b0, we});
    for (int i = 0; i < 4; i++) begin
      if (we) push(K_WR, oh, base + 32'(8 * i), ((idx == 0) ? W0 : W1) + 64'(i));
      else    push(K_RD, oh, 32'h0, mem_model(base + 32'(8 * i)));
    end
    push(K_DONE, oh, 32'h0, 64'h0);
  endtask

  task automatic mon(input kind_t k, input logic [1:0] v, input logic [31:0] a, input logic [63:0] d);
    exp_t e;
    bit   bad;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_%s: got vec %b addr %h data %h expected no event", k.name(), v, a, d);
    end else begin
      e   = sb.pop_front();
      bad = (e.kind != k) || (e.vec !== v)
            || ((k == K_ADDR || k == K_WR) && e.addr !== a)
            || ((k != K_DONE) && e.data !== d);
      if (bad) begin
        mismatched++;
        $display("FAIL event_%s: got %s vec %b addr %h data %h expected %s vec %b addr %h data %h",
                 k.name(), k.name(), v, a, d, e.kind.name(), e.vec, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_addrstb) mon(K_ADDR, gnt, mem_addr, {63'b0, mem_we});
      if (|wr_next)    mon(K_WR, wr_next, mem_addr, mem_wdata);
      if (|rd_valid)   mon(K_RD, rd_valid, 32'h0, rdata);
      if (|done)       mon(K_DONE, done, 32'h0, 64'h0);
    end
  end

  // One clock; requesters advance their write beat after each accepted wr_next.
  task automatic cyc();
    logic [1:0] wn;
    @(negedge clk);
    wn = wr_next;
    @(posedge clk);
    #1;
    if (wn[0]) req_wdata0 = req_wdata0 + 64'd1;
    if (wn[1]) req_wdata1 = req_wdata1 + 64'd1;
  endtask

  task automatic reset_pulse();
    req = '0;
    reset = 1'b1;
    #1;
    chk("async_reset_gnt", 64'(gnt), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_done(input int idx, input string name);
    bit found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc();
      if (done[idx]) begin
        req[idx] = 1'b0;
        found = 1;
      end
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got no done expected done[%0d]", name, idx);
    end
  endtask

  task automatic burst(input int idx, input bit we, input logic [31:0] a, input logic [31:0] base,
                       input int nstall, input bit drop, output int ncyc);
    bit found = 0;
    ncyc = 0;
    push_burst(idx, we, base);
    if (idx == 0) begin req_addr0 = a; req_wdata0 = W0; end
    else          begin req_addr1 = a; req_wdata1 = W1; end
    req_we[idx] = we;
    mem_stb = 1'b1;
    req[idx] = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc();
      ncyc++;
      if (k == 0) chk("burst_gnt", 64'(gnt), (idx == 0) ? 64'd1 : 64'd2);
      mem_stb = (k >= 1 && k <= nstall) ? 1'b0 : 1'b1;
      if (drop && k == 2) begin
        req[idx] = 1'b0;
        if (idx == 0) req_addr0 = 32'hDEAD_BEEF; else req_addr1 = 32'hDEAD_BEEF;
      end
      if (done[idx]) begin
        req[idx] = 1'b0;
        found = 1;
      end
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("FAIL burst_timeout: got no done expected done[%0d]", idx);
    end
    cyc();
  endtask

  task automatic contend(input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1);
    push_burst(0, 1'b0, b0);
    push_burst(1, 1'b1, b1);
    req_addr0 = a0; req_addr1 = a1;
    req_we = 2'b10; req_wdata1 = W1; mem_stb = 1'b1;
    req = 2'b11;
    cyc();
    chk("contend_first_gnt", 64'(gnt), 64'd1);
    wait_done(0, "contend_done0");
    cyc();
    chk("contend_gap_gnt", 64'(gnt), 64'd0);
    cyc();
    chk("contend_second_gnt", 64'(gnt), 64'd2);
    wait_done(1, "contend_done1");
    cyc();
  endtask

  initial begin
    int n;
    bit [6:0] pat;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 64'(gnt), 64'h0);
    chk("reset_addrstb", 64'(mem_addrstb), 64'h0);
    chk("reset_mem_addr", 64'(mem_addr), 64'h0);
    chk("reset_rdata", rdata, 64'h0);
    chk("reset_pulses", 64'({wr_next, rd_valid, done}), 64'h0);
    reset = 1'b0;

    // Single read, mem_stb held high throughout
    burst(0, 1'b0, 32'h0000_1234, 32'h0000_1220, 0, 0, n);
    chk("read_req_to_done_cycles", 64'(n), 64'd6);

    // Write with stalls: strobe 1,0,0,1,1,0,1 during XFER
    pat = 7'b1011001;
    push_burst(1, 1'b1, 32'h0000_7000);
    req_addr1 = 32'h0000_7010; req_we = 2'b10; req_wdata1 = W1; mem_stb = 1'b1;
    req = 2'b10;
    cyc();
    chk("write_gnt", 64'(gnt), 64'd2);
    cyc();
    for (int j = 0; j < 7; j++) begin
      mem_stb = pat[j];
      cyc();
    end
    chk("write_done_after_4th_beat", 64'(done), 64'd2);
    req = 2'b00;
    cyc();

    // Contention from reset, then again with the pointer back at requester 0
    reset_pulse();
    contend(32'h0000_2000, 32'h0000_2000, 32'h0000_305F, 32'h0000_3040);
    contend(32'h0000_20A8, 32'h0000_20A0, 32'h0000_3100, 32'h0000_3100);

    // Request and address dropped mid-burst
    burst(0, 1'b0, 32'h0000_4010, 32'h0000_4000, 0, 1, n);
    chk("drop_burst_cycles", 64'(n), 64'd6);

    // Reset after two beats of a read
    push(K_ADDR, 2'b01, 32'h0000_5000, 64'h0);
    push(K_RD, 2'b01, 32'h0, mem_model(32'h0000_5000));
    push(K_RD, 2'b01, 32'h0, mem_model(32'h0000_5008));
    req_addr0 = 32'h0000_5004; req_we = 2'b00; mem_stb = 1'b1;
    req = 2'b01;
    repeat (4) cyc();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset_gnt", 64'(gnt), 64'h0);
    chk("midreset_addrstb", 64'(mem_addrstb), 64'h0);
    chk("midreset_mem_addr", 64'(mem_addr), 64'h0);
    chk("midreset_rdata", rdata, 64'h0);
    chk("midreset_pulses", 64'({wr_next, rd_valid, done, mem_we}), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    burst(0, 1'b0, 32'h0000_6008, 32'h0000_6000, 0, 0, n);
    chk("restart_cycles", 64'(n), 64'd6);

`ifdef ARB_STATS_EN
    reset_pulse();
    burst(0, 1'b0, 32'h0000_8000, 32'h0000_8000, 2, 0, n);
    burst(0, 1'b1, 32'h0000_8020, 32'h0000_8020, 0, 0, n);
    burst(1, 1'b0, 32'h0000_9000, 32'h0000_9000, 3, 0, n);
    burst(0, 1'b0, 32'h0000_8040, 32'h0000_8040, 0, 0, n);
    burst(1, 1'b1, 32'h0000_9020, 32'h0000_9020, 0, 0, n);
    chk("stat_grants0", 64'(stat_grants0), 64'd3);
    chk("stat_grants1", 64'(stat_grants1), 64'd2);
    chk("stat_wait", 64'(stat_wait), 64'd5);
    chk("stat_contention", 64'(stat_contention), 64'd0);
`endif

    repeat (2) cyc();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    mismatched++;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule
